// File: rtl/sram_like_arbiter.sv
//------------------------------------------------------------------------------
// Module : sram_like_arbiter
// Merges inst/data sram-like ports onto one master port and routes responses back.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam int C_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int C_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int C_STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(MAX_OUTSTANDING);
  localparam logic [C_STV_W-1:0] C_STV_MAX  = C_STV_W'(STARVE_LIMIT);

  // Owner bit per outstanding transaction: 1 = data port, 0 = inst port.
  logic [MAX_OUTSTANDING-1:0] r_owner;
  logic [C_PTR_W-1:0]         r_wptr;
  logic [C_PTR_W-1:0]         r_rptr;
  logic [C_CNT_W-1:0]         r_count;
  logic [C_STV_W-1:0]         r_starve;

  logic w_full;
  logic w_empty;
  logic w_starved;
  logic w_sel_data;
  logic w_sel_inst;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_head_owner;
  logic [C_PTR_W-1:0] w_wptr_nxt;
  logic [C_PTR_W-1:0] w_rptr_nxt;

  assign w_full    = (r_count == C_FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_starved = (r_starve == C_STV_MAX);

  // Data normally wins; a starved waiting inst request overrides it.
  assign w_sel_data = data_req & ~(inst_req & w_starved);
  assign w_sel_inst = inst_req & ~w_sel_data;

  assign m_req = (inst_req | data_req) & ~w_full;

  always_comb begin
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    if (w_sel_data) begin
      m_wr    = data_wr;
      m_size  = data_size;
      m_addr  = data_addr;
      m_wdata = data_wdata;
    end else if (w_sel_inst) begin
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_addr  = inst_addr;
      m_wdata = inst_wdata;
    end
  end

  assign w_accept     = m_addr_ok & m_req;
  assign data_addr_ok = w_accept & w_sel_data;
  assign inst_addr_ok = w_accept & w_sel_inst;
  assign w_push       = w_accept;

  // A response with nothing outstanding is dropped; pop looks at pre-push state.
  assign w_pop        = m_data_ok & ~w_empty;
  assign w_head_owner = r_owner[r_rptr];
  assign data_data_ok = w_pop & w_head_owner;
  assign inst_data_ok = w_pop & ~w_head_owner;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  assign w_wptr_nxt = (r_wptr == C_PTR_LAST) ? '0 : r_wptr + C_PTR_W'(1);
  assign w_rptr_nxt = (r_rptr == C_PTR_LAST) ? '0 : r_rptr + C_PTR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_owner[r_wptr] <= w_sel_data;
        r_wptr          <= w_wptr_nxt;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      r_starve <= '0;
    end else if (data_addr_ok && !w_starved) begin
      r_starve <= r_starve + C_STV_W'(1);
    end
  end

endmodule

`default_nettype wire
